cipher_out_buffer: RTL



---
 rtl/cipher_out_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/cipher_out_buffer.sv
// Buffers final-round AES blocks and streams each one out as four 32-bit words, MSW first.
// Latency: a block pushed into an empty buffer is presented as word 0 the cycle after its edge.
// Backpressure: out_ready stalls the word stream; input cannot stall, so a full buffer drops the block and sets overflow.
module cipher_out_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [127:0]             in_block,
    input  logic                     out_ready,
    output logic [31:0]              out_word,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [1:0]    widx;

    logic          full;
    logic          xfer;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [127:0]  head;

    // Full/empty come from the block count only; the pointers wrap freely.
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign out_valid = (cnt != '0);
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (widx == 2'd3);
    // A pop on the same edge frees the slot the incoming block needs.
    assign push_ok   = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;
    assign head      = mem[rp];
    assign out_last  = out_valid && (widx == 2'd3);
    assign level     = cnt;

    // Select the current word of the head block; zero when nothing is held.
    always_comb begin
        out_word = 32'd0;
        if (out_valid) begin
            case (widx)
                2'd0:    out_word = head[127:96];
                2'd1:    out_word = head[95:64];
                2'd2:    out_word = head[63:32];
                default: out_word = head[31:0];
            endcase
        end
    end

    // Block storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= in_block;
        end
    end

    // Pointers, block count, word index and the sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            widx     <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wp <= wp + AW'(1);
            end
            if (xfer) begin
                widx <= widx + 2'd1;
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
